// File: rtl/div3_pkg.sv
// -----------------------------------------------------------------------------
// div3_pkg
// Shared types and helpers for the divide-by-3 serial stream blocks.
//   div3_state_e : transmitter FSM states
//   div3_res_t   : 2-bit residue (mod 3)
//   div3_step_t  : result of one MSB-first serial division step
//   div3_step()  : (res, bit) -> (next_res, qbit)
// -----------------------------------------------------------------------------
package div3_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } div3_state_e;

    typedef logic [1:0] div3_res_t;

    typedef struct packed {
        div3_res_t next_res;
        logic      qbit;
    } div3_step_t;

    // Remainder code that is out of range for a divide-by-3.
    localparam logic [1:0] BadRem = 2'd3;

    // One long-division step: t = 2*res + b, qbit = (t >= 3), next_res = t mod 3.
    function automatic div3_step_t div3_step(input div3_res_t res, input logic b);
        div3_step_t s;
        logic [2:0] t;
        t = {res, b};
        s.qbit = (t >= 3'd3);
        unique case (t)
            3'd0, 3'd3, 3'd6: s.next_res = 2'd0;
            3'd1, 3'd4, 3'd7: s.next_res = 2'd1;
            default:          s.next_res = 2'd2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/div3_residue.sv
// -----------------------------------------------------------------------------
// div3_residue
// Serial MSB-first divide-by-3 datapath: tracks the running residue and
// reports the quotient bit produced by the current input bit.
// Ports:
//   clock      : clock, rising edge
//   reset      : synchronous active-low reset
//   clear_i    : restart residue at 0 (start of a new frame)
//   step_en_i  : consume bit_i this cycle
//   bit_i      : dividend bit, MSB first
//   res_o      : current residue (after all consumed bits)
//   qbit_o     : quotient bit for bit_i given the current residue
// -----------------------------------------------------------------------------
module div3_residue
    import div3_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      clear_i,
    input  logic      step_en_i,
    input  logic      bit_i,
    output div3_res_t res_o,
    output logic      qbit_o
);

    div3_res_t  res_q, res_d;
    div3_step_t step;

    always_comb begin
        step  = div3_step(res_q, bit_i);
        res_d = res_q;
        if (clear_i) begin
            res_d = '0;
        end else if (step_en_i) begin
            res_d = step.next_res;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign res_o  = res_q;
    assign qbit_o = step.qbit;

endmodule

// File: rtl/div3_stream_tx.sv
// -----------------------------------------------------------------------------
// div3_stream_tx
// Accepts a quotient/remainder pair (q, r), rebuilds d = 3*q + r as a W+2-bit
// word and streams it MSB-first with first/last framing, followed by GAP idle
// cycles. r == 3 is accepted but treated as 0 and flagged on bad_rem.
// Optional self-check (define DIV3_STREAM_TX_SELFCHECK_EN): runs a serial
// divide-by-3 over the emitted bits and sets sticky chk_err if the recovered
// quotient/remainder disagree with the latched pair.
// Ports:
//   clock, reset            : clock and synchronous active-low reset
//   in_valid/in_ready       : input handshake (ready only in IDLE)
//   in_quot[W-1:0], in_rem  : pair to transmit
//   out_bit/out_valid/out_ready : serial output handshake
//   out_first, out_last     : MSB / LSB markers
//   bad_rem                 : one-cycle pulse after accepting r == 3
//   chk_err                 : sticky self-check error (0 when check absent)
// -----------------------------------------------------------------------------
module div3_stream_tx
    import div3_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned GAP = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_quot,
    input  logic [1:0]   in_rem,
    output logic         out_bit,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_first,
    output logic         out_last,
    output logic         bad_rem,
    output logic         chk_err
);

    localparam int unsigned   DW      = W + 2;
    localparam int unsigned   CW      = $clog2(DW);
    localparam logic [CW-1:0] CntTop  = CW'(W + 1);
    localparam logic [3:0]    GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    div3_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] d_q, d_d;
    logic [3:0]    gap_q, gap_d;
    logic          bad_q, bad_d;

    logic          xfer, beat;
    logic [1:0]    r_eff;
    logic [DW-1:0] d_new;

    assign xfer  = in_valid && in_ready;
    assign beat  = out_valid && out_ready;
    assign r_eff = (in_rem == BadRem) ? 2'd0 : in_rem;
    assign d_new = (DW'(in_quot) << 1) + DW'(in_quot) + DW'(r_eff);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) state_d = StShift;
            end
            StShift: begin
                if (beat && cnt_q == '0) state_d = (GAP > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (gap_q == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StShift);
        out_bit   = out_valid && d_q[cnt_q];
        out_first = out_valid && (cnt_q == CntTop);
        out_last  = out_valid && (cnt_q == '0);
        bad_rem   = bad_q;
    end

    // Datapath next state
    always_comb begin
        cnt_d = cnt_q;
        d_d   = d_q;
        gap_d = gap_q;
        bad_d = 1'b0;
        if (xfer) begin
            cnt_d = CntTop;
            d_d   = d_new;
            bad_d = (in_rem == BadRem);
        end
        // Counter parks at 0 after the last beat so d_q is never indexed out of range.
        if (beat && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (beat && cnt_q == '0) begin
            gap_d = GapLoad;
        end else if (state_q == StGap && gap_q != '0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            d_q   <= '0;
            gap_q <= '0;
            bad_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            d_q   <= d_d;
            gap_q <= gap_d;
            bad_q <= bad_d;
        end
    end

`ifdef DIV3_STREAM_TX_SELFCHECK_EN
    logic [W-1:0] q_q, q_d;
    div3_res_t    r_q, r_d;
    logic [W-1:0] qrec_q, qrec_d;
    logic         pend_q, pend_d;
    logic         err_q, err_d;
    div3_res_t    res;
    logic         qbit;

    div3_residue u_residue (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (xfer),
        .step_en_i (beat),
        .bit_i     (out_bit),
        .res_o     (res),
        .qbit_o    (qbit)
    );

    // Compare one cycle after the last beat, when the residue register holds
    // the final remainder; a back-to-back transfer only clears it at the edge.
    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        qrec_d = qrec_q;
        err_d  = err_q;
        pend_d = beat && out_last;
        if (xfer) begin
            q_d    = in_quot;
            r_d    = r_eff;
            qrec_d = '0;
        end
        if (beat) begin
            qrec_d = {qrec_q[W-2:0], qbit};
        end
        if (pend_q && (qrec_q != q_q || res != r_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_q    <= '0;
            r_q    <= '0;
            qrec_q <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            qrec_q <= qrec_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_div3_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_div3_stream_tx
// Directed bench for div3_stream_tx (W=8). u_dut uses GAP=1, u_dut_g0 uses
// GAP=0 and is driven with in_valid held high for back-to-back frames.
// -----------------------------------------------------------------------------
module tb_div3_stream_tx;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       in_valid, in_ready, out_bit, out_valid, out_ready;
    logic       out_first, out_last, bad_rem, chk_err;
    logic [7:0] in_quot;
    logic [1:0] in_rem;

    logic       in_valid_b, in_ready_b, out_bit_b, out_valid_b, out_ready_b;
    logic       out_first_b, out_last_b, bad_rem_b, chk_err_b;
    logic [7:0] in_quot_b;
    logic [1:0] in_rem_b;

    int n_vec = 0;
    int n_bad = 0;

    div3_stream_tx #(.W(8), .GAP(1)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_quot   (in_quot),
        .in_rem    (in_rem),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .bad_rem   (bad_rem),
        .chk_err   (chk_err)
    );

    div3_stream_tx #(.W(8), .GAP(0)) u_dut_g0 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_quot   (in_quot_b),
        .in_rem    (in_rem_b),
        .out_bit   (out_bit_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_first (out_first_b),
        .out_last  (out_last_b),
        .bad_rem   (bad_rem_b),
        .chk_err   (chk_err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for in_ready, then hold one transfer cycle.
    task automatic send(input logic [7:0] q, input logic [1:0] r);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check_eq("send_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_quot  = q;
        in_rem   = r;
        tick();
        in_valid = 1'b0;
    endtask

    // Gather beats until the out_last beat; returns in that beat's cycle.
    task automatic collect(output logic [9:0] bits, output int nb, output int fpos,
                           output int lpos, output int nbad);
        bits = '0;
        nb   = 0;
        fpos = 0;
        lpos = 0;
        nbad = 0;
        for (int t = 0; t < 100; t++) begin
            if (bad_rem) nbad++;
            if (out_valid && out_ready) begin
                bits = {bits[8:0], out_bit};
                nb++;
                if (out_first) fpos = nb;
                if (out_last) begin
                    lpos = nb;
                    break;
                end
            end
            tick();
        end
    endtask

    logic [9:0]  bits;
    logic [3:0]  pre;
    int          nb, fpos, lpos, nbad;
    logic [9:0]  exp_d, got_d;
    logic        b2b_pend;
    int          frames;
    logic [1:0]  r_eff;

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_quot     = '0;
        in_rem      = '0;
        out_ready   = 1'b1;
        in_valid_b  = 1'b0;
        in_quot_b   = '0;
        in_rem_b    = '0;
        out_ready_b = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Reset state
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_bit", 32'(out_bit), 32'd0);
        check_eq("rst_out_first", 32'(out_first), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_bad_rem", 32'(bad_rem), 32'd0);
        check_eq("rst_chk_err", 32'(chk_err), 32'd0);

        // q=85 r=2 -> d=257 = 0100000001
        send(8'd85, 2'd2);
        collect(bits, nb, fpos, lpos, nbad);
        check_eq("f257_bits", 32'(bits), 32'h101);
        check_eq("f257_nb", 32'(nb), 32'd10);
        check_eq("f257_first", 32'(fpos), 32'd1);
        check_eq("f257_last", 32'(lpos), 32'd10);
        check_eq("f257_bad", 32'(nbad), 32'd0);
        tick();
        tick();
        check_eq("f257_chk_err", 32'(chk_err), 32'd0);

        // q=255 r=2 -> d=767 = 1011111111; in_ready back 2 cycles after last beat
        send(8'd255, 2'd2);
        collect(bits, nb, fpos, lpos, nbad);
        check_eq("f767_bits", 32'(bits), 32'h2FF);
        check_eq("f767_nb", 32'(nb), 32'd10);
        tick();
        check_eq("f767_gap_ready", 32'(in_ready), 32'd0);
        check_eq("f767_gap_valid", 32'(out_valid), 32'd0);
        tick();
        check_eq("f767_idle_ready", 32'(in_ready), 32'd1);

        // q=10 r=3 -> treated as r=0, d=30 = 0000011110, one bad_rem pulse
        send(8'd10, 2'd3);
        collect(bits, nb, fpos, lpos, nbad);
        check_eq("f30_bits", 32'(bits), 32'h01E);
        check_eq("f30_bad_pulses", 32'(nbad), 32'd1);
        tick();
        tick();
        check_eq("f30_chk_err", 32'(chk_err), 32'd0);

        // q=100 r=1 -> d=301 = 0100101101; stall 3 cycles at cnt=5 (bit d[5]=1)
        send(8'd100, 2'd1);
        pre = '0;
        for (int i = 0; i < 4; i++) begin
            pre = {pre[2:0], out_bit};
            tick();
        end
        check_eq("stall_prefix", 32'(pre), 32'h4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_hold", 32'({out_valid, out_bit, out_first, out_last}), 32'hC);
            tick();
        end
        out_ready = 1'b1;
        collect(bits, nb, fpos, lpos, nbad);
        check_eq("stall_tail_bits", 32'(bits), 32'h02D);
        check_eq("stall_tail_nb", 32'(nb), 32'd6);
        check_eq("stall_tail_first", 32'(fpos), 32'd0);
        check_eq("stall_tail_last", 32'(lpos), 32'd6);
        tick();
        tick();

        // Mid-frame reset at cnt=4, then q=1 r=0 -> 0000000011
        send(8'd85, 2'd2);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        send(8'd1, 2'd0);
        collect(bits, nb, fpos, lpos, nbad);
        check_eq("midrst_new_bits", 32'(bits), 32'h003);
        check_eq("midrst_new_nb", 32'(nb), 32'd10);
        tick();
        tick();

        // GAP=0 instance, in_valid held high, random pairs and output stalls
        in_valid_b = 1'b1;
        frames     = 0;
        b2b_pend   = 1'b0;
        exp_d      = '0;
        got_d      = '0;
        for (int c = 0; c < 40000 && frames < 1000; c++) begin
            in_quot_b   = 8'($urandom_range(255));
            in_rem_b    = 2'($urandom_range(3));
            out_ready_b = ($urandom_range(3) != 0);
            if (b2b_pend) begin
                check_eq("g0_b2b_ready", 32'(in_ready_b), 32'd1);
                b2b_pend = 1'b0;
            end
            if (in_ready_b) begin
                r_eff = (in_rem_b == 2'd3) ? 2'd0 : in_rem_b;
                exp_d = 10'(3 * int'(in_quot_b) + int'(r_eff));
                got_d = '0;
            end
            if (out_valid_b && out_ready_b) begin
                got_d = {got_d[8:0], out_bit_b};
                if (out_last_b) begin
                    check_eq("g0_frame", 32'(got_d), 32'(exp_d));
                    frames++;
                    b2b_pend = 1'b1;
                end
            end
            tick();
        end
        check_eq("g0_frames", 32'(frames), 32'd1000);
        tick();
        check_eq("g0_chk_err", 32'(chk_err_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/div3_stream_tx.md
DIV3_STREAM_TX -- requirements
Module: div3_stream_tx

Interface
REQ-001 SHALL provide parameter W, default 8, quotient width in bits (legal 2..30).
REQ-002 SHALL provide parameter GAP, default 1, idle cycles after each frame's last bit (legal 0..15).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clock.
REQ-005 SHALL have port in_valid  input  1  the offered quotient/remainder pair is valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts a pair this cycle.
REQ-007 SHALL have port in_quot  input  W  quotient q.
REQ-008 SHALL have port in_rem  input  2  remainder r (legal values 0..2).
REQ-009 SHALL have port out_bit  output  1  serial dividend bit, MSB-first.
REQ-010 SHALL have port out_valid  output  1  out_bit is valid.
REQ-011 SHALL have port out_ready  input  1  the consumer takes out_bit this cycle.
REQ-012 SHALL have port out_first  output  1  qualifies the MSB of the frame.
REQ-013 SHALL have port out_last  output  1  qualifies the LSB of the frame.
REQ-014 SHALL have port bad_rem  output  1  one-cycle pulse when an accepted r equals 3.
REQ-015 SHALL have port chk_err  output  1  sticky self-check error flag.

Function
REQ-016 SHALL reconstruct the dividend d = 3*q + r as a W+2-bit value and emit it serially for the MSB-first serial divide-by-3 receiver.
REQ-017 SHALL implement FSM states IDLE, SHIFT and GAP.
REQ-018 SHALL assert in_ready only in IDLE; a transfer is in_valid && in_ready.
REQ-019 SHALL, on a transfer, latch d, q and r, load the bit counter with W+1, and enter SHIFT.
REQ-020 SHALL present the first bit in the cycle after the transfer (latency 1).
REQ-021 SHALL, in SHIFT, assert out_valid and drive out_bit = d[cnt]; a beat is out_valid && out_ready.
REQ-022 SHALL, on each beat, decrement cnt.
REQ-023 SHALL, on the beat with cnt = 0, go to GAP if GAP > 0, otherwise go to IDLE.
REQ-024 SHALL, while out_ready is low, hold out_bit, out_first, out_last and cnt unchanged, so no bit is skipped or repeated.
REQ-025 SHALL assert out_first only when cnt = W+1, and out_last only when cnt = 0, each qualified by out_valid.
REQ-026 SHALL, in GAP, hold out_valid and in_ready low for exactly GAP cycles, then enter IDLE.
REQ-027 SHALL, when r = 3, accept the pair, use r = 0 (d = 3q), and pulse bad_rem in the cycle after the transfer.
REQ-028 SHALL compute arithmetic unsigned without overflow: the maximum d is 3*(2^W-1)+2 = 3*2^W-1, which fits in W+2 bits.
REQ-029 SHALL ignore in_valid outside IDLE (no queuing).

Reset
REQ-030 SHALL, while reset is low at a clock edge, enter IDLE and clear cnt, d, and the residue and quotient trackers.
REQ-031 SHALL produce these output values the cycle after reset: in_ready=1, out_valid=0, out_bit=0, out_first=0, out_last=0, bad_rem=0, chk_err=0.
REQ-032 SHALL abort any frame in progress on a mid-frame reset; no further bits of that frame are emitted.

Configuration
REQ-033 SHALL, with DIV3_STREAM_TX_SELFCHECK_EN defined, run a serial divide-by-3 model on each beat: res <= (2*res + out_bit) mod 3, and the quotient bit equals (2*res + out_bit) >= 3.
REQ-034 SHALL, in that configuration, compare the recovered quotient bits (low W of W+2) against q and the final res against r at the out_last beat; on mismatch it sets chk_err until reset.
REQ-035 SHALL, without DIV3_STREAM_TX_SELFCHECK_EN, tie chk_err to 0, include no checker logic, and leave all other behaviour identical.

Structure
REQ-036 SHALL place the FSM state enum, the 2-bit residue type, and a residue-step function (res, bit) -> (next_res, qbit) in a shared package div3_pkg.
REQ-037 SHALL instantiate the self-check datapath as sub-module div3_residue (clock, reset, step enable, bit in; residue and quotient-bit out), reusable by the receiver side.

Verification
REQ-038 SHALL verify W=8, q=85, r=2: d=257; out_bit sequence 0100000001; out_first on bit 1; out_last on bit 10; chk_err=0.
REQ-039 SHALL verify W=8, q=255, r=2: d=767; sequence 1011111111; in_ready returns high GAP+1=2 cycles after the out_last beat.
REQ-040 SHALL verify q=10, r=3: bad_rem pulses once; sequence is d=30, i.e. 0000011110.
REQ-041 SHALL verify out_ready held low 3 cycles at cnt=5: out_bit, out_valid and cnt are stable; the frame completes with all 10 bits exactly once.
REQ-042 SHALL verify reset low for 1 cycle at cnt=4: out_valid=0 and in_ready=1 next cycle; a new pair q=1, r=0 then emits 0000000011.
REQ-043 SHALL verify in_valid held high continuously with GAP=0: the next transfer occurs in the IDLE cycle immediately after the out_last beat; with the macro on, chk_err stays 0 over 1000 random pairs.
